// File: rtl/dso_pkg.sv
// Shared types and constants for the sample-capture path.
package dso_pkg;

  localparam int unsigned DEPTH    = 512;
  localparam int unsigned AW       = 9;
  localparam int unsigned WR_PULSE = 2;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ARMED,
    POST,
    DONE
  } cap_state_t;

endpackage

// File: rtl/trig_detect.sv
// Combinational trigger compare: reports a threshold crossing between the
// previous and current sample in the selected direction.
module trig_detect #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] prev_i,
  input  logic [W-1:0] smpl_i,
  input  logic [W-1:0] level_i,
  input  logic         edge_i,
  input  logic         prev_vld_i,
  output logic         hit_o
);

  logic rise;
  logic fall;

  assign rise  = (prev_i < level_i) && (smpl_i >= level_i);
  assign fall  = (prev_i > level_i) && (smpl_i <= level_i);
  assign hit_o = prev_vld_i && (edge_i ? rise : fall);

endmodule

// File: rtl/capture_ctrl.sv
// Acquisition controller: writes the strobed ADC stream into the sample RAM as
// a circular buffer, detects the trigger and stops after trig_pos more samples.
module capture_ctrl #(
  parameter int unsigned DEPTH = dso_pkg::DEPTH,
  parameter int unsigned AW    = dso_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          arm,
  input  logic          smpl_vld,
  input  logic [7:0]    smpl,
  input  logic [7:0]    trig_level,
  input  logic          trig_edge,
  input  logic [AW-1:0] trig_pos,
  input  logic          force_trig,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  output logic          busy,
  output logic          triggered,
  output logic          done,
  output logic [AW-1:0] trig_addr
);
  import dso_pkg::*;

  localparam int unsigned PLW      = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

  cap_state_t    state_q;
  logic [AW-1:0] wptr_q, post_cnt_q, trig_pos_q, trig_addr_q, ram_addr_q;
  logic [AW:0]   pre_cnt_q;
  logic [7:0]    level_q, prev_q, ram_wdata_q;
  logic          edge_q, prev_vld_q, force_seen_q, done_pend_q;
  logic          ram_en_q, busy_q, triggered_q, done_q;
  logic [PLW-1:0] pulse_left_q;

  logic          capturing, accept, hit, trig_now, pulse_end;
  logic [AW-1:0] wptr_d, post_cnt_d;
  logic [AW:0]   pre_cnt_d, pre_thr, arm_thr;

  trig_detect #(.W(8)) u_trig_detect (
    .prev_i     (prev_q),
    .smpl_i     (smpl),
    .level_i    (level_q),
    .edge_i     (edge_q),
    .prev_vld_i (prev_vld_q),
    .hit_o      (hit)
  );

  assign capturing  = state_q inside {PRE, ARMED, POST};
  assign accept     = smpl_vld && capturing && !arm;
  assign wptr_d     = wptr_q + 1'b1;
  assign post_cnt_d = post_cnt_q + 1'b1;
  assign pre_cnt_d  = (&pre_cnt_q) ? pre_cnt_q : pre_cnt_q + 1'b1;
  assign pre_thr    = LAST_IDX - {1'b0, trig_pos_q};
  assign arm_thr    = LAST_IDX - {1'b0, trig_pos};
  assign trig_now   = hit || force_seen_q || force_trig;
  assign pulse_end  = ram_en_q && (pulse_left_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      post_cnt_q   <= '0;
      pre_cnt_q    <= '0;
      trig_pos_q   <= '0;
      trig_addr_q  <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      level_q      <= '0;
      prev_q       <= '0;
      edge_q       <= 1'b0;
      prev_vld_q   <= 1'b0;
      force_seen_q <= 1'b0;
      done_pend_q  <= 1'b0;
      ram_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
      pulse_left_q <= '0;
    end else begin
      // The write pulse ignores arm so an in-flight RAM write always completes.
      if (accept) begin
        ram_en_q     <= 1'b1;
        ram_addr_q   <= wptr_q;
        ram_wdata_q  <= smpl;
        pulse_left_q <= PLW'(WR_PULSE - 1);
      end else if (ram_en_q) begin
        if (pulse_left_q == '0) ram_en_q <= 1'b0;
        else                    pulse_left_q <= pulse_left_q - 1'b1;
      end

      if (arm) begin
        wptr_q       <= '0;
        pre_cnt_q    <= '0;
        post_cnt_q   <= '0;
        triggered_q  <= 1'b0;
        done_q       <= 1'b0;
        done_pend_q  <= 1'b0;
        prev_vld_q   <= 1'b0;
        force_seen_q <= 1'b0;
        level_q      <= trig_level;
        edge_q       <= trig_edge;
        trig_pos_q   <= trig_pos;
        busy_q       <= 1'b1;
        state_q      <= (arm_thr == '0) ? ARMED : PRE;
      end else begin
        // done waits for the last write pulse to finish before it is reported.
        if (pulse_end && done_pend_q) begin
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          done_pend_q <= 1'b0;
        end
        if (accept) begin
          wptr_q     <= wptr_d;
          prev_q     <= smpl;
          prev_vld_q <= 1'b1;
        end
        unique case (state_q)
          PRE: begin
            if (accept) begin
              pre_cnt_q <= pre_cnt_d;
              if (pre_cnt_d >= pre_thr) state_q <= ARMED;
            end
          end
          ARMED: begin
            if (force_trig) force_seen_q <= 1'b1;
            if (accept && trig_now) begin
              trig_addr_q <= wptr_q;
              triggered_q <= 1'b1;
              post_cnt_q  <= '0;
              if (trig_pos_q == '0) begin
                state_q     <= DONE;
                done_pend_q <= 1'b1;
              end else begin
                state_q <= POST;
              end
            end
          end
          POST: begin
            if (accept) begin
              post_cnt_q <= post_cnt_d;
              if (post_cnt_d == trig_pos_q) begin
                state_q     <= DONE;
                done_pend_q <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_en_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;
  assign triggered = triggered_q;
  assign done      = done_q;
  assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: table-driven captures, hand-written
// corner sequences and randomized captures against a sample-index model.
module tb_capture_ctrl;
  localparam int unsigned DEPTH   = 512;
  localparam int unsigned AW      = 9;
  localparam int          NS      = 1300;
  localparam int unsigned P_RAMP  = 0;
  localparam int unsigned P_FALL  = 1;
  localparam int unsigned P_STEP  = 2;
  localparam int unsigned P_CONST = 3;
  localparam int unsigned P_HOLD  = 4;

  logic          clk, rst_n, arm, smpl_vld, trig_edge, force_trig;
  logic [7:0]    smpl, trig_level, ram_wdata;
  logic [AW-1:0] trig_pos, ram_addr, trig_addr;
  logic          ram_en, ram_we, busy, triggered, done;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [AW-1:0] addr; logic [7:0] data; } wr_t;
  wr_t        wr_q[$];
  logic [7:0] samp [NS];

  typedef struct {
    int unsigned pat;
    int          tp;
    logic [7:0]  lvl;
    logic        edg;
    int          fidx;
    int          exp_k;
  } vec_t;
  vec_t tbl [6];

  capture_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .smpl_vld   (smpl_vld),
    .smpl       (smpl),
    .trig_level (trig_level),
    .trig_edge  (trig_edge),
    .trig_pos   (trig_pos),
    .force_trig (force_trig),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .busy       (busy),
    .triggered  (triggered),
    .done       (done),
    .trig_addr  (trig_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Write monitor: each sample must appear as exactly one 2-cycle RAM pulse.
  initial begin : mon
    wr_t         cur;
    bit          half;
    int unsigned run;
    half = 1'b0;
    run  = 0;
    cur  = '0;
    forever begin
      @(negedge clk);
      if (ram_en) begin
        run++;
        if (!half) begin
          cur.addr = ram_addr;
          cur.data = ram_wdata;
          wr_q.push_back(cur);
          chk("ram_we", 32'(ram_we), 32'(ram_en));
          half = 1'b1;
        end else begin
          chk("wr_hold", 32'({ram_we, ram_addr, ram_wdata}), 32'({1'b1, cur.addr, cur.data}));
          half = 1'b0;
        end
      end else begin
        if (run != 0) chk("wr_pulse_len", run % 2, 32'd0);
        run  = 0;
        half = 1'b0;
      end
    end
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  function automatic logic [7:0] pat_val(input int unsigned pat, input int unsigned i);
    case (pat)
      P_RAMP:  return 8'(i);
      P_FALL:  return (i < 5) ? 8'h80 : (i < 8) ? 8'h10 : (i < 20) ? 8'h80 : 8'h30;
      P_STEP:  return (i < 411) ? 8'h00 : 8'h50;
      P_CONST: return 8'h55;
      P_HOLD:  return (i < 300) ? 8'h60 : 8'h61;
      default: return 8'h00;
    endcase
  endfunction

  // Trigger index from the sample list: first sample at or beyond the
  // pre-trigger count that crosses the level, or any sample at or after a force.
  function automatic int find_trig(input int thr, input logic [7:0] lvl, input logic edg, input int fidx);
    for (int k = thr; k < NS; k++) begin
      if (fidx >= thr && k >= fidx) return k;
      if (k >= 1) begin
        if (edg  && samp[k-1] < lvl && samp[k] >= lvl) return k;
        if (!edg && samp[k-1] > lvl && samp[k] <= lvl) return k;
      end
    end
    return -1;
  endfunction

  task automatic run_capture(input string tag, input int tp, input logic [7:0] lvl,
                             input logic edg, input int fidx, input int k);
    int  last;
    int  gap;
    int  nbad;
    int  nchk;
    wr_t e;
    last = k + tp;
    wr_q.delete();
    trig_pos = AW'(tp); trig_level = lvl; trig_edge = edg; arm = 1'b1;
    cyc();
    arm = 1'b0;
    at_neg();
    chk({tag, "_arm"}, 32'({busy, triggered, done}), 32'b100);
    cyc();
    for (int i = 0; i <= last + 3; i++) begin
      if (i == fidx) begin
        force_trig = 1'b1;
        cyc();
        force_trig = 1'b0;
      end
      smpl = samp[i];
      smpl_vld = 1'b1;
      if (i == k) begin
        at_neg();
        chk({tag, "_trig_before"}, 32'(triggered), 32'd0);
      end
      cyc();
      smpl_vld = 1'b0;
      at_neg();
      if (i == k)
        chk({tag, "_trig"}, 32'({triggered, trig_addr}), 32'({1'b1, AW'(k % DEPTH)}));
      if (i == last) begin
        chk({tag, "_done_n1"}, 32'({busy, done}), 32'b10);
        cyc(); at_neg();
        chk({tag, "_done_n2"}, 32'({busy, done}), 32'b10);
        cyc(); at_neg();
        chk({tag, "_done_n3"}, 32'({busy, done}), 32'b01);
        cyc();
      end else begin
        gap = int'($urandom_range(1, 2));
        repeat (gap) cyc();
      end
    end
    repeat (3) cyc();
    at_neg();
    chk({tag, "_writes"}, 32'(wr_q.size()), 32'(last + 1));
    nbad = 0;
    nchk = (wr_q.size() < last + 1) ? wr_q.size() : last + 1;
    for (int j = 0; j < nchk; j++) begin
      e.addr = AW'(j % DEPTH);
      e.data = samp[j];
      if (wr_q[j] !== e) nbad++;
    end
    chk({tag, "_wr_content_bad"}, 32'(nbad), 32'd0);
    chk({tag, "_final"}, 32'({busy, triggered, done, trig_addr}), 32'({3'b011, AW'(k % DEPTH)}));
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; smpl_vld = 1'b0; smpl = '0;
    trig_level = '0; trig_edge = 1'b0; trig_pos = '0; force_trig = 1'b0;

    // Reset, then samples and a force while idle.
    repeat (3) cyc();
    at_neg();
    chk("reset_out", 32'({ram_en, ram_we, ram_addr, ram_wdata, busy, triggered, done, trig_addr}), 32'h0);
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 6; i++) begin
      smpl = 8'($urandom); smpl_vld = 1'b1; force_trig = (i == 2);
      cyc();
      smpl_vld = 1'b0; force_trig = 1'b0;
      cyc();
    end
    at_neg();
    chk("idle_out", 32'({ram_en, ram_we, ram_addr, ram_wdata, busy, triggered, done, trig_addr}), 32'h0);
    chk("idle_writes", 32'(wr_q.size()), 32'd0);
    cyc();

    // {pattern, trig_pos, level, edge, force index, expected trigger sample index}
    tbl[0] = '{P_RAMP,  256, 8'h80, 1'b1,  -1, 384};
    tbl[1] = '{P_FALL,  500, 8'h40, 1'b0,  -1,  20};
    tbl[2] = '{P_STEP,  100, 8'h50, 1'b1,  -1, 411};
    tbl[3] = '{P_CONST,   0, 8'h55, 1'b1, 520, 520};
    tbl[4] = '{P_RAMP,  511, 8'h10, 1'b1,  -1,  16};
    tbl[5] = '{P_HOLD,   10, 8'h60, 1'b1, 700, 700};
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NS; i++) samp[i] = pat_val(tbl[r].pat, i);
      run_capture($sformatf("tbl%0d", r), tbl[r].tp, tbl[r].lvl, tbl[r].edg, tbl[r].fidx, tbl[r].exp_k);
    end

    // arm together with smpl_vld: sample dropped, next sample lands at address 0.
    wr_q.delete();
    trig_pos = AW'(10); trig_level = 8'h80; trig_edge = 1'b1;
    arm = 1'b1; smpl = 8'hAA; smpl_vld = 1'b1;
    cyc();
    arm = 1'b0; smpl_vld = 1'b0;
    repeat (4) cyc();
    at_neg();
    chk("arm_vld_drop", 32'(wr_q.size()), 32'd0);
    chk("arm_vld_state", 32'({busy, triggered, done}), 32'b100);
    cyc();
    smpl = 8'h5A; smpl_vld = 1'b1;
    cyc();
    smpl_vld = 1'b0;
    repeat (3) cyc();
    at_neg();
    chk("arm_vld_next_cnt", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() >= 1) chk("arm_vld_next_wr", 32'(wr_q[0]), 32'({9'd0, 8'h5A}));
    cyc();

    // arm in the middle of POST while a write pulse is in flight.
    wr_q.delete();
    trig_pos = AW'(511); trig_level = 8'h00; trig_edge = 1'b1; arm = 1'b1;
    cyc();
    arm = 1'b0; force_trig = 1'b1;
    cyc();
    force_trig = 1'b0;
    for (int i = 0; i < 5; i++) begin
      smpl = 8'(8'h30 + i); smpl_vld = 1'b1;
      cyc();
      smpl_vld = 1'b0;
      if (i < 4) cyc();
    end
    arm = 1'b1;
    at_neg();
    chk("midpost_pulse1", 32'({ram_en, ram_addr, ram_wdata}), 32'({1'b1, 9'd4, 8'h34}));
    chk("midpost_before", 32'({busy, triggered, done, trig_addr}), 32'({3'b110, 9'd0}));
    cyc();
    arm = 1'b0;
    at_neg();
    chk("midpost_pulse2", 32'({ram_en, ram_addr, ram_wdata}), 32'({1'b1, 9'd4, 8'h34}));
    chk("midpost_rearm", 32'({busy, triggered, done}), 32'b100);
    cyc();
    at_neg();
    chk("midpost_pulse_end", 32'(ram_en), 32'd0);
    cyc();
    smpl = 8'h77; smpl_vld = 1'b1;
    cyc();
    smpl_vld = 1'b0;
    repeat (3) cyc();
    at_neg();
    chk("midpost_wr_cnt", 32'(wr_q.size()), 32'd6);
    if (wr_q.size() >= 6) begin
      chk("midpost_inflight_wr", 32'(wr_q[4]), 32'({9'd4, 8'h34}));
      chk("midpost_restart_wr", 32'(wr_q[5]), 32'({9'd0, 8'h77}));
    end
    chk("midpost_force_cleared", 32'(triggered), 32'd0);
    cyc();

    // Randomized captures: noisy signal around the level, force as a backstop.
    for (int r = 0; r < 6; r++) begin
      int         tp;
      int         thr;
      int         fidx;
      int         k;
      logic [7:0] lvl;
      logic       edg;
      tp   = (r == 0) ? 0 : (r == 1) ? 511 : int'($urandom_range(0, 511));
      lvl  = 8'($urandom_range(8'h20, 8'hE0));
      edg  = 1'($urandom);
      for (int i = 0; i < NS; i++) samp[i] = 8'(int'(lvl) + int'($urandom_range(0, 48)) - 24);
      thr  = 511 - tp;
      fidx = thr + int'($urandom_range(0, 300));
      k    = find_trig(thr, lvl, edg, fidx);
      run_capture($sformatf("rnd%0d", r), tp, lvl, edg, fidx, k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
